// File: rtl/dds_sine_gen.sv
// dds_sine_gen
// Direct digital synthesis sine generator. A 32-bit phase accumulator
// advances every clock by (freq + freq_add). The top 10 phase bits address a
// 1024-point sine table, which is stored as a 256-entry quarter wave and
// expanded by address mirroring and sign inversion.
//
// The sample path has three register stages after the accumulator:
// address, ROM output, and DAC output. This gives a fixed 3-clock latency
// from phase to sample.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high; clears every register
//   freq       in   [31:0] base tuning word
//   freq_add   in   [31:0] offset tuning word, added to freq modulo 2^32
//   dac_signal out  [15:0] two's-complement sine sample
//   phase      out  [31:0] current accumulator value (unregistered copy)
module dds_sine_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] freq,
  input  logic [31:0] freq_add,
  output logic [15:0] dac_signal,
  output logic [31:0] phase
);

  localparam real TWO_PI = 6.283185307179586476925;

  logic        [31:0] step;
  logic        [31:0] acc_q, acc_d;
  logic        [9:0]  addr_q, addr_d;
  logic signed [15:0] rom_q, rom_d;
  logic signed [15:0] dac_q, dac_d;

  logic signed [15:0] qtab [0:255];
  logic        [7:0]  off;
  logic        [7:0]  idx;
  logic signed [15:0] mag;

  // Quarter-wave table entries, evaluated at elaboration. $rtoi truncates
  // toward zero, which matches the reference formula.
  for (genvar g = 0; g < 256; g++) begin : g_qtab
    localparam logic signed [15:0] QV =
      16'($rtoi(32767.0 * $sin(TWO_PI * real'(g) / 1024.0)));
    assign qtab[g] = QV;
  end

  // The second half-wave is the first half-wave negated. Magnitudes never
  // exceed 32767, so the negation cannot overflow and 0x8000 is never produced.
  function automatic logic signed [15:0] apply_sign(
    input logic signed [15:0] m,
    input logic               neg
  );
    return neg ? -m : m;
  endfunction

  // Tuning word wraps modulo 2^32; freq_add = -freq therefore stops the phase.
  assign step   = freq + freq_add;
  assign acc_d  = acc_q + step;
  assign addr_d = acc_q[31:22];

  // Odd quadrants read the table backwards, at index 256 - off.
  // The peak at off == 0 in those quadrants lies outside the 256-entry table,
  // so it is supplied directly.
  always_comb begin
    off   = addr_q[7:0];
    idx   = addr_q[8] ? 8'(~off + 8'd1) : off;
    mag   = qtab[idx];
    if (addr_q[8] && (off == 8'd0)) begin
      mag = 16'sd32767;
    end
    rom_d = apply_sign(mag, addr_q[9]);
  end

  assign dac_d = rom_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      addr_q <= '0;
      rom_q  <= '0;
      dac_q  <= '0;
    end else begin
      // accumulator
      acc_q  <= acc_d;
      // stage 1: table address
      addr_q <= addr_d;
      // stage 2: table lookup
      rom_q  <= rom_d;
      // stage 3: DAC sample
      dac_q  <= dac_d;
    end
  end

  assign phase      = acc_q;
  assign dac_signal = dac_q;

endmodule

// File: tb/tb_dds_sine_gen.sv
module tb_dds_sine_gen;

  localparam real TWO_PI = 6.283185307179586476925;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] freq = '0;
  logic [31:0] freq_add = '0;
  logic [15:0] dac_signal;
  logic [31:0] phase;

  int checks = 0;
  int errors = 0;

  logic [15:0] swept [0:1023];

  dds_sine_gen dut (
    .clk        (clk),
    .reset      (reset),
    .freq       (freq),
    .freq_add   (freq_add),
    .dac_signal (dac_signal),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sin_ref(input int a);
    real r;
    r = 32767.0 * $sin(TWO_PI * real'(a) / 1024.0);
    return 16'($rtoi(r));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_phase", phase, 32'h0);
    chk("rst_dac", {16'h0, dac_signal}, 32'h0);
    reset = 1'b0;
  endtask

  // Run from reset release with freq = 0x0147AEB8 and check the first six edges.
  task automatic seq_1mhz(input string pfx);
    logic [31:0] ph_exp [1:4];
    logic [15:0] dac_exp [1:6];
    ph_exp[1] = 32'h0147AEB8; ph_exp[2] = 32'h028F5D70;
    ph_exp[3] = 32'h03D70C28; ph_exp[4] = 32'h051EBAE0;
    dac_exp[1] = 16'h0000; dac_exp[2] = 16'h0000; dac_exp[3] = 16'h0000;
    dac_exp[4] = 16'h03ED; dac_exp[5] = 16'h07D9; dac_exp[6] = 16'h0BC3;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k <= 4) chk({pfx, "_phase"}, phase, ph_exp[k]);
      chk({pfx, "_dac"}, {16'h0, dac_signal}, {16'h0, dac_exp[k]});
    end
  endtask

  initial begin
    logic [31:0] prev;
    logic [15:0] exp16;

    // Test 1: 1 MHz at 200 MHz from reset
    freq = 32'h0147AEB8;
    freq_add = 32'h0;
    do_reset();
    seq_1mhz("t1");

    // Test 4: asynchronous reset between edges, then restart
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("t4_async_phase", phase, 32'h0);
    chk("t4_async_dac", {16'h0, dac_signal}, 32'h0);
    tick();
    reset = 1'b0;
    seq_1mhz("t4");

    // Test 2: quarter-turn step
    freq = 32'h40000000;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("t2_phase", phase, 32'h40000000 * k);
      case (k)
        4: chk("t2_dac", {16'h0, dac_signal}, 32'h7FFF);
        5: chk("t2_dac", {16'h0, dac_signal}, 32'h0000);
        6: chk("t2_dac", {16'h0, dac_signal}, 32'h8001);
        7: chk("t2_dac", {16'h0, dac_signal}, 32'h0000);
        default: ;
      endcase
    end

    // Test 3: cancelling tuning words, then a nonzero offset
    freq = 32'h01000000;
    freq_add = 32'hFF000000;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_frozen_phase", phase, 32'h0);
      chk("t3_frozen_dac", {16'h0, dac_signal}, 32'h0);
    end
    freq_add = 32'h00400000;
    for (int k = 0; k < 4; k++) begin
      prev = phase;
      tick();
      chk("t3_incr", phase - prev, 32'h01400000);
    end

    // Test 5: full table sweep, one address per clock
    freq = 32'h00400000;
    freq_add = 32'h0;
    do_reset();
    for (int k = 1; k <= 1027; k++) begin
      tick();
      if (k >= 4) begin
        exp16 = sin_ref((k - 3) % 1024);
        chk("t5_sweep", {16'h0, dac_signal}, {16'h0, exp16});
        swept[(k - 3) % 1024] = dac_signal;
      end
    end
    for (int a = 0; a < 512; a++) begin
      chk("t5_odd_sym", {16'h0, swept[a + 512]}, {16'h0, 16'(-swept[a])});
    end
    for (int a = 0; a < 1024; a++) begin
      checks++;
      assert (swept[a] !== 16'h8000) else begin
        errors++;
        $error("FAIL t5_no_8000: observed %h at addr %0d expected not 8000", swept[a], a);
      end
    end

    // Test 6: tuning word change mid-run
    freq = 32'h0147AEB8;
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    chk("t6_before", phase, 32'h0147AEB8 * 5);
    freq = 32'h028F5D70;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t6_after", phase, 32'h0147AEB8 * 5 + 32'h028F5D70 * k);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_sine_gen.md
Name: dds_sine_gen

Overview:
Direct digital synthesis (DDS) sine generator for the LLRF analog front end. A 32-bit phase accumulator advances each clock by the sum of a base tuning word and an offset tuning word. The top 10 phase bits address an internal 1024-point sine table. The 16-bit signed sample drives the DAC, and the raw accumulator phase is exported for phase-tracking logic.

Parameters:
none. All widths are fixed: phase 32 bits, table address 10 bits, sample 16 bits.

Ports:
clk  input  1  system clock; all registers update on the rising edge
reset  input  1  reset, asynchronous, active-high
freq  input  32  base tuning word = Fout·2^32/Fclk
freq_add  input  32  offset tuning word, added to freq (e.g. feedback correction)
dac_signal  output  16  sine sample, two's complement
phase  output  32  current phase accumulator value

Behaviour:
- Tuning word
  - step = (freq + freq_add) mod 2^32.
  - Combinational, no carry out.
  - Sampled every cycle, so a change takes effect on the next rising edge.
- Phase accumulator
  - On each rising edge with reset low: acc <= (acc + step) mod 2^32.
  - Wraps silently past 0xFFFFFFFF.
  - phase = acc directly, with no extra register.
- Sine table (internal, no external IP)
  - SIN(a) = trunc(32767·sin(2π·a/1024)) for a = 0..1023, truncated toward zero.
  - The table is odd-symmetric: SIN(a+512) = −SIN(a).
  - SIN(0) = SIN(512) = 0x0000; SIN(256) = 0x7FFF; SIN(768) = 0x8001.
  - The value 0x8000 never occurs.
  - Implementation may be a full 1024-entry ROM or a 256-entry quarter-wave ROM with address mirroring and sign inversion. Either must be bit-exact to the formula.
- Pipeline (3 registered stages after the accumulator)
  - Stage 1: addr <= acc[31:22].
  - Stage 2: rom_q <= SIN(addr).
  - Stage 3: dac_signal <= rom_q.
  - Let phase(k) be the accumulator value after rising edge k. Then dac_signal(k) = SIN(phase(k−3)[31:22]).
  - Fixed latency is 3 clocks from phase to sample. No handshake; output is valid every cycle.
- Reset
  - Asynchronous: acc, addr, rom_q and dac_signal clear to 0 immediately.
  - Held reset: phase = 0x00000000 and dac_signal = 0x0000.
  - After release: the first rising edge gives phase = step. dac_signal stays 0 until SIN of the first nonzero address reaches stage 3.
  - Reset asserted mid-operation discards all pipeline contents. There is no glitch beyond returning to 0.
- Boundary cases
  - step = 0: phase frozen and dac_signal constant.
  - step = 0x80000000: alternates SIN(0) and SIN(512), both 0.
  - freq + freq_add overflow wraps, so freq_add = −freq gives step = 0.

Test Plan:
1. Reset, then freq=0x0147AEB8, freq_add=0 (1 MHz @ 200 MHz):
   - phase = 0x00000000 during reset, then 0x0147AEB8, 0x028F5D70, 0x03D70C28, 0x051EBAE0 on successive edges.
   - dac_signal = 0x0000 through edge 3, then 0x03ED, 0x07D9, 0x0BC3 (table addresses 5, 10, 15).
2. freq=0x40000000, freq_add=0 from reset:
   - phase cycles 0x40000000, 0x80000000, 0xC0000000, 0x00000000 (wrap).
   - dac_signal follows 3 cycles later: 0x7FFF, 0x0000, 0x8001, 0x0000.
3. freq=0x01000000, freq_add=0xFF000000:
   - step = 0, phase stays 0, dac_signal stays 0x0000.
   - Then set freq_add=0x00400000: phase increments by 0x01400000 per clock.
4. Assert reset asynchronously mid-stream (between clock edges):
   - phase and dac_signal go to 0 without a clock edge.
   - After release, the sequence restarts exactly as in test 1.
5. Table sweep with step=0x00400000 (one address per clock) over 1024 cycles:
   - Every dac_signal equals the trunc(32767·sin) reference.
   - Odd symmetry holds and 0x8000 is never produced.
6. Change freq mid-run from 0x0147AEB8 to 0x028F5D70:
   - The next phase increment equals the new step on the following edge, with no discontinuity in the accumulated phase.
